// File: rtl/axi4_on_chip_ram.sv
// ID-less AXI4 slave over a single-port synchronous RAM; serves one burst at a time.
// Optional macro AXI4_OCRAM_SLVERR_EN: beats addressed beyond the RAM span answer SLVERR.
module axi4_on_chip_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned WORD_COUNT = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    io_axi_aw_valid,
    output logic                    io_axi_aw_ready,
    input  logic [ADDR_WIDTH-1:0]   io_axi_aw_payload_addr,
    input  logic [7:0]              io_axi_aw_payload_len,
    input  logic [2:0]              io_axi_aw_payload_size,
    input  logic [1:0]              io_axi_aw_payload_burst,
    input  logic                    io_axi_w_valid,
    output logic                    io_axi_w_ready,
    input  logic [DATA_WIDTH-1:0]   io_axi_w_payload_data,
    input  logic [DATA_WIDTH/8-1:0] io_axi_w_payload_strb,
    input  logic                    io_axi_w_payload_last,
    output logic                    io_axi_b_valid,
    input  logic                    io_axi_b_ready,
    output logic [1:0]              io_axi_b_payload_resp,
    input  logic                    io_axi_ar_valid,
    output logic                    io_axi_ar_ready,
    input  logic [ADDR_WIDTH-1:0]   io_axi_ar_payload_addr,
    input  logic [7:0]              io_axi_ar_payload_len,
    input  logic [2:0]              io_axi_ar_payload_size,
    input  logic [1:0]              io_axi_ar_payload_burst,
    output logic                    io_axi_r_valid,
    input  logic                    io_axi_r_ready,
    output logic [DATA_WIDTH-1:0]   io_axi_r_payload_data,
    output logic [1:0]              io_axi_r_payload_resp,
    output logic                    io_axi_r_payload_last
);
    localparam int unsigned STRB_W   = DATA_WIDTH / 8;
    localparam int unsigned IDX_W    = $clog2(WORD_COUNT);
    localparam int unsigned LSB      = $clog2(STRB_W);
    localparam logic [2:0]  MAX_SIZE = 3'(LSB);
    localparam logic [1:0]  B_FIXED  = 2'd0;
    localparam logic [1:0]  B_INCR   = 2'd1;
    localparam logic [1:0]  B_WRAP   = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WRITE_RESP, S_READ} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              len_q, len_d, cnt_q, cnt_d;
    logic [2:0]              size_q, size_d;
    logic [1:0]              burst_q, burst_d;
    logic                    err_q, err_d;
    logic                    aw_ready_q, aw_ready_d, ar_ready_q, ar_ready_d;
    logic                    w_ready_q, w_ready_d, b_valid_q, b_valid_d;
    logic [1:0]              b_resp_q, b_resp_d, r_resp_q, r_resp_d;
    logic                    r_valid_q, r_valid_d, r_last_q, r_last_d;
    logic [DATA_WIDTH-1:0]   r_data_q, r_data_d;

    logic [DATA_WIDTH-1:0]   mem [WORD_COUNT];
    logic [IDX_W-1:0]        word_idx_c;
    logic [DATA_WIDTH-1:0]   mem_rdata_c;
    logic                    mem_we_c, addr_err_c;
    logic                    aw_hs_c, ar_hs_c, w_hs_c;
    logic [ADDR_WIDTH-1:0]   req_addr_c, next_addr_c;
    logic [7:0]              req_len_c;
    logic [2:0]              req_size_c;
    logic [1:0]              req_burst_c;
    logic                    req_bad_c;
    logic                    unused_ok;

    assign unused_ok = io_axi_w_payload_last;

    // AR must not appear accepted in a cycle where a competing AW wins arbitration.
    assign io_axi_aw_ready       = aw_ready_q;
    assign io_axi_ar_ready       = ar_ready_q & ~io_axi_aw_valid;
    assign io_axi_w_ready        = w_ready_q;
    assign io_axi_b_valid        = b_valid_q;
    assign io_axi_b_payload_resp = b_resp_q;
    assign io_axi_r_valid        = r_valid_q;
    assign io_axi_r_payload_data = r_data_q;
    assign io_axi_r_payload_resp = r_resp_q;
    assign io_axi_r_payload_last = r_last_q;

    assign aw_hs_c = io_axi_aw_valid & aw_ready_q;
    assign ar_hs_c = io_axi_ar_valid & io_axi_ar_ready;
    assign w_hs_c  = io_axi_w_valid & w_ready_q;

    assign req_addr_c  = io_axi_aw_valid ? io_axi_aw_payload_addr  : io_axi_ar_payload_addr;
    assign req_len_c   = io_axi_aw_valid ? io_axi_aw_payload_len   : io_axi_ar_payload_len;
    assign req_size_c  = io_axi_aw_valid ? io_axi_aw_payload_size  : io_axi_ar_payload_size;
    assign req_burst_c = io_axi_aw_valid ? io_axi_aw_payload_burst : io_axi_ar_payload_burst;
    assign req_bad_c   = (req_size_c > MAX_SIZE) || (req_burst_c == 2'd3);

    assign word_idx_c  = addr_q[LSB +: IDX_W];
    assign mem_rdata_c = mem[word_idx_c];

`ifdef AXI4_OCRAM_SLVERR_EN
    assign addr_err_c = |addr_q[ADDR_WIDTH-1:IDX_W+LSB];
`else
    assign addr_err_c = 1'b0;
`endif

    // Next beat address; WRAP keeps the bits above the (len+1)*2^size window.
    always_comb begin
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] mask;
        inc  = addr_q + (ADDR_WIDTH'(1) << size_q);
        mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
        case (burst_q)
            B_FIXED: next_addr_c = addr_q;
            B_WRAP:  next_addr_c = (addr_q & ~mask) | (inc & mask);
            default: next_addr_c = inc;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        r_valid_d = r_valid_q;
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;
        r_last_d  = r_last_q;
        mem_we_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (aw_hs_c || ar_hs_c) begin
                    addr_d  = req_addr_c;
                    len_d   = req_len_c;
                    size_d  = req_bad_c ? MAX_SIZE : req_size_c;
                    burst_d = req_bad_c ? B_INCR : req_burst_c;
                    cnt_d   = 8'd0;
                    err_d   = 1'b0;
                    state_d = aw_hs_c ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                if (w_hs_c) begin
                    mem_we_c = ~addr_err_c;
                    err_d    = err_q | addr_err_c;
                    addr_d   = next_addr_c;
                    cnt_d    = cnt_q + 8'd1;
                    if (cnt_q == len_q) state_d = S_WRITE_RESP;
                end
            end
            S_WRITE_RESP: begin
                if (io_axi_b_ready) state_d = S_IDLE;
            end
            S_READ: begin
                // cnt_q is the index of the next beat to fetch; fetch on first entry or on handshake.
                if (!r_valid_q || io_axi_r_ready) begin
                    if (r_valid_q && r_last_q) begin
                        r_valid_d = 1'b0;
                        r_last_d  = 1'b0;
                        r_resp_d  = 2'b00;
                        state_d   = S_IDLE;
                    end else begin
                        r_valid_d = 1'b1;
                        r_data_d  = addr_err_c ? '0 : mem_rdata_c;
                        r_resp_d  = {addr_err_c, 1'b0};
                        r_last_d  = (cnt_q == len_q);
                        cnt_d     = cnt_q + 8'd1;
                        addr_d    = next_addr_c;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        aw_ready_d = (state_d == S_IDLE);
        ar_ready_d = (state_d == S_IDLE);
        w_ready_d  = (state_d == S_WRITE);
        b_valid_d  = (state_d == S_WRITE_RESP);
        b_resp_d   = (state_d == S_WRITE_RESP) ? {err_d, 1'b0} : 2'b00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            aw_ready_q <= 1'b0;
            ar_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= 2'b00;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= 2'b00;
            r_last_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            size_q     <= size_d;
            burst_q    <= burst_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            aw_ready_q <= aw_ready_d;
            ar_ready_q <= ar_ready_d;
            w_ready_q  <= w_ready_d;
            b_valid_q  <= b_valid_d;
            b_resp_q   <= b_resp_d;
            r_valid_q  <= r_valid_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
            r_last_q   <= r_last_d;
        end
    end

    // RAM array: byte-lane writes, contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (io_axi_w_payload_strb[b]) mem[word_idx_c][8*b +: 8] <= io_axi_w_payload_data[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi4_on_chip_ram.sv
// Directed bench for axi4_on_chip_ram: table of bursts plus hand-written multi-cycle corner cases.
module tb_axi4_on_chip_ram;
    logic        clk = 1'b0;
    logic        reset;
    logic        aw_valid, aw_ready, ar_valid, ar_ready;
    logic [31:0] aw_addr, ar_addr;
    logic [7:0]  aw_len, ar_len;
    logic [2:0]  aw_size, ar_size;
    logic [1:0]  aw_burst, ar_burst;
    logic        w_valid, w_ready, w_last;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        b_valid, b_ready;
    logic [1:0]  b_resp;
    logic        r_valid, r_ready, r_last;
    logic [31:0] r_data;
    logic [1:0]  r_resp;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] beat_data [4];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  strb;
        bit          stall;
        logic [31:0] d0, d1, d2, d3;
    } vec_t;

    vec_t vecs [18];

    axi4_on_chip_ram dut (
        .clk(clk), .reset(reset),
        .io_axi_aw_valid(aw_valid), .io_axi_aw_ready(aw_ready),
        .io_axi_aw_payload_addr(aw_addr), .io_axi_aw_payload_len(aw_len),
        .io_axi_aw_payload_size(aw_size), .io_axi_aw_payload_burst(aw_burst),
        .io_axi_w_valid(w_valid), .io_axi_w_ready(w_ready),
        .io_axi_w_payload_data(w_data), .io_axi_w_payload_strb(w_strb),
        .io_axi_w_payload_last(w_last),
        .io_axi_b_valid(b_valid), .io_axi_b_ready(b_ready), .io_axi_b_payload_resp(b_resp),
        .io_axi_ar_valid(ar_valid), .io_axi_ar_ready(ar_ready),
        .io_axi_ar_payload_addr(ar_addr), .io_axi_ar_payload_len(ar_len),
        .io_axi_ar_payload_size(ar_size), .io_axi_ar_payload_burst(ar_burst),
        .io_axi_r_valid(r_valid), .io_axi_r_ready(r_ready),
        .io_axi_r_payload_data(r_data), .io_axi_r_payload_resp(r_resp),
        .io_axi_r_payload_last(r_last)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                                input bit stall, input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3);
        vec_t v;
        v.wr = wr; v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.strb = strb;
        v.stall = stall; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Entered at posedge+1; writes beat_data[0..len] and collects the B response.
    task automatic do_write(input string nm, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb);
        int n;
        aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst; aw_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!aw_ready && n < 50) begin @(negedge clk); n++; end
        check({nm, "_aw_hs"}, 32'(aw_ready), 32'd1);
        @(posedge clk); #1;
        aw_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            w_valid = 1'b1; w_data = beat_data[2'(i)]; w_strb = strb; w_last = (i == int'(len));
            n = 0;
            @(negedge clk);
            while (!w_ready && n < 50) begin @(negedge clk); n++; end
            if (!w_ready) check({nm, "_w_hs"}, 32'(w_ready), 32'd1);
            @(posedge clk); #1;
        end
        w_valid = 1'b0; w_last = 1'b0;
        b_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!b_valid && n < 50) begin @(negedge clk); n++; end
        check({nm, "_b_valid"}, 32'(b_valid), 32'd1);
        check({nm, "_b_resp"}, 32'(b_resp), 32'd0);
        @(posedge clk); #1;
        b_ready = 1'b0;
    endtask

    // Entered at posedge+1; expects beat_data[0..len]; toggle alternates r_ready every cycle.
    task automatic do_read(input string nm, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit toggle);
        int n, beat, lat;
        bit stalled;
        logic [31:0] held;
        ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst; ar_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ar_ready && n < 50) begin @(negedge clk); n++; end
        check({nm, "_ar_hs"}, 32'(ar_ready), 32'd1);
        @(posedge clk); #1;
        ar_valid = 1'b0; r_ready = 1'b1;
        beat = 0; n = 0; lat = -1; stalled = 1'b0; held = '0;
        while (beat <= int'(len) && n < 100) begin
            @(negedge clk); n++;
            if (stalled) begin
                check({nm, "_hold_valid"}, 32'(r_valid), 32'd1);
                check({nm, "_hold_data"}, r_data, held);
            end
            if (r_valid) begin
                if (lat < 0) lat = n;
                if (r_ready) begin
                    check({nm, "_data"}, r_data, beat_data[2'(beat)]);
                    check({nm, "_last"}, 32'(r_last), 32'(beat == int'(len)));
                    check({nm, "_resp"}, 32'(r_resp), 32'd0);
                    beat++; stalled = 1'b0;
                end else begin
                    held = r_data; stalled = 1'b1;
                end
            end
            @(posedge clk); #1;
            if (toggle) r_ready = ~r_ready;
        end
        r_ready = 1'b0;
        check({nm, "_latency"}, 32'(lat), 32'd2);
        check({nm, "_beats"}, 32'(beat), 32'(len) + 32'd1);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        aw_valid = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
        ar_valid = 0; ar_addr = 0; ar_len = 0; ar_size = 0; ar_burst = 0;
        w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0; r_ready = 0;

        vecs[0]  = mk(1, 32'h10,   0, 2, 1, 4'hF, 0, 32'hDEADBEEF, 0, 0, 0);
        vecs[1]  = mk(0, 32'h10,   0, 2, 1, 4'hF, 0, 32'hDEADBEEF, 0, 0, 0);
        vecs[2]  = mk(1, 32'h100,  3, 2, 1, 4'hF, 0, 1, 2, 3, 4);
        vecs[3]  = mk(0, 32'h100,  3, 2, 1, 4'hF, 0, 1, 2, 3, 4);
        vecs[4]  = mk(1, 32'h20,   0, 2, 1, 4'hF, 0, 32'h12345678, 0, 0, 0);
        vecs[5]  = mk(1, 32'h20,   0, 2, 1, 4'h3, 0, 32'hAAAA5555, 0, 0, 0);
        vecs[6]  = mk(0, 32'h20,   0, 2, 1, 4'hF, 0, 32'h12345555, 0, 0, 0);
        vecs[7]  = mk(0, 32'h108,  3, 2, 2, 4'hF, 0, 3, 4, 1, 2);
        vecs[8]  = mk(1, 32'h200,  3, 2, 0, 4'hF, 0, 5, 6, 7, 8);
        vecs[9]  = mk(0, 32'h200,  1, 2, 0, 4'hF, 0, 8, 8, 0, 0);
        vecs[10] = mk(1, 32'h1030, 0, 2, 1, 4'hF, 0, 32'hCAFEF00D, 0, 0, 0);
        vecs[11] = mk(0, 32'h30,   0, 2, 1, 4'hF, 0, 32'hCAFEF00D, 0, 0, 0);
        vecs[12] = mk(1, 32'h304,  1, 2, 2, 4'hF, 0, 32'hA, 32'hB, 0, 0);
        vecs[13] = mk(0, 32'h300,  1, 2, 1, 4'hF, 0, 32'hB, 32'hA, 0, 0);
        vecs[14] = mk(0, 32'h100,  1, 1, 1, 4'hF, 0, 1, 1, 0, 0);
        vecs[15] = mk(0, 32'h100,  1, 7, 1, 4'hF, 0, 1, 2, 0, 0);
        vecs[16] = mk(0, 32'h100,  1, 2, 3, 4'hF, 0, 1, 2, 0, 0);
        vecs[17] = mk(0, 32'h100,  3, 2, 1, 4'hF, 1, 1, 2, 3, 4);

        // Reset values, then ready rises one edge after release.
        @(negedge clk);
        check("rst_aw_ready", 32'(aw_ready), 32'd0);
        check("rst_ar_ready", 32'(ar_ready), 32'd0);
        check("rst_w_ready", 32'(w_ready), 32'd0);
        check("rst_b_valid", 32'(b_valid), 32'd0);
        check("rst_r_valid", 32'(r_valid), 32'd0);
        check("rst_r_data", r_data, 32'd0);
        check("rst_r_last", 32'(r_last), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_aw_ready", 32'(aw_ready), 32'd1);
        check("idle_ar_ready", 32'(ar_ready), 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            beat_data[0] = vecs[i].d0; beat_data[1] = vecs[i].d1;
            beat_data[2] = vecs[i].d2; beat_data[3] = vecs[i].d3;
            if (vecs[i].wr) do_write(nm, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst, vecs[i].strb);
            else            do_read(nm, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst, vecs[i].stall);
        end

        // AW and AR together: the write must finish first, so the read sees new data.
        beat_data[0] = 32'h0BADF00D;
        ar_addr = 32'h400; ar_len = 0; ar_size = 2; ar_burst = 1; ar_valid = 1'b1;
        do_write("both_wr", 32'h400, 0, 2, 1, 4'hF);
        do_read("both_rd", 32'h400, 0, 2, 1, 0);

        // Reset in the middle of a stalled read burst.
        ar_addr = 32'h100; ar_len = 3; ar_size = 2; ar_burst = 1; ar_valid = 1'b1; r_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!ar_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        ar_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("midrd_r_valid", 32'(r_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("midrd_rst_r_valid", 32'(r_valid), 32'd0);
        check("midrd_rst_r_last", 32'(r_last), 32'd0);
        check("midrd_rst_r_data", r_data, 32'd0);
        check("midrd_rst_aw_ready", 32'(aw_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrd_idle_aw_ready", 32'(aw_ready), 32'd1);
        check("midrd_idle_r_valid", 32'(r_valid), 32'd0);
        @(posedge clk); #1;
        beat_data[0] = 1; beat_data[1] = 2; beat_data[2] = 3; beat_data[3] = 4;
        do_read("after_rst", 32'h100, 3, 2, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
